// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO over a valid/ready stream.
// Frames go out LSB first as start / data / [parity] / stop bits. A frame follows
// the previous one with no idle gap while the FIFO holds data.
// Optional feature macro: UART_TX_PARITY_EN adds one parity bit per frame.
// The bit is even parity, or odd parity when PARITY_ODD=1.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              axi_valid,
  output logic                              axi_ready,
  input  logic [DATA_W-1:0]                 axi_data,
  output logic                              uart_tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT*2);
  localparam int IDX_W  = $clog2(DATA_W+1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT-1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W-1);
  localparam logic              STOP_LAST = 1'(STOP_BITS-1);

  // Reject parameter values outside the supported ranges at elaboration.
  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              full, empty, push, pop;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud, baud_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              stop_cnt, stop_nxt;
  logic              tx_nxt;
  logic [DATA_W-1:0] shift;

  // Bit i of a word, using a shift so the index may be wider than the word.
  function automatic logic bit_at(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] s;
    s = w >> i;
    return s[0];
  endfunction

`ifdef UART_TX_PARITY_EN
  // Parity over the data word, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_W-1:0] w);
    logic odd;
    odd = (PARITY_ODD != 0);
    return (^w) ^ odd;
  endfunction
`endif

  assign full       = (count == LVL_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign axi_ready  = !full && !rst;
  assign push       = axi_valid && axi_ready;
  assign fifo_level = count;

  // FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage; the word is captured only on the push edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axi_data;
  end

  // Serializer next-state logic; the line value is registered one cycle ahead.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    idx_nxt   = idx;
    stop_nxt  = stop_cnt;
    tx_nxt    = uart_tx;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          idx_nxt   = '0;
          tx_nxt    = shift[0];
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_nxt = '0;
          if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_nxt    = parity_bit(shift);
            state_nxt = S_PARITY;
`else
            tx_nxt    = 1'b1;
            stop_nxt  = 1'b0;
            state_nxt = S_STOP;
`endif
          end else begin
            idx_nxt = idx + 1'b1;
            tx_nxt  = bit_at(shift, idx_nxt);
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          tx_nxt    = 1'b1;
          stop_nxt  = 1'b0;
          state_nxt = S_STOP;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud == BAUD_LAST) begin
          baud_nxt = '0;
          if (stop_cnt == STOP_LAST) begin
            stop_nxt = 1'b0;
            // Chain straight into the next start bit when data is waiting.
            if (!empty) begin
              pop       = 1'b1;
              tx_nxt    = 1'b0;
              state_nxt = S_START;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = S_IDLE;
            end
          end else begin
            stop_nxt = 1'b1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Serializer control registers; reset truncates any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud     <= baud_nxt;
      idx      <= idx_nxt;
      stop_cnt <= stop_nxt;
      uart_tx  <= tx_nxt;
      busy     <= (state_nxt != S_IDLE);
    end
  end

  // Shift register loads the popped word; it holds data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (pop) shift <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. Instance 0 is the default configuration.
// Instance 1 uses two stop bits and one clock per bit.
// With UART_TX_PARITY_EN defined, instances 2/3 add even/odd parity.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int NDUT = 4;
`else
  localparam int NDUT = 2;
`endif

  logic       clk;
  logic       rst;
  logic       valid [NDUT];
  logic [7:0] data  [NDUT];
  logic       ready [NDUT];
  logic       tx    [NDUT];
  logic       busy  [NDUT];
  logic [2:0] level [NDUT];

  int n_tests;
  int n_fail;
  logic [7:0] exp_q [$];
  logic [7:0] w6 [6];

  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .axi_valid(valid[0]), .axi_ready(ready[0]), .axi_data(data[0]),
    .uart_tx(tx[0]), .busy(busy[0]), .fifo_level(level[0]));

  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(1), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .axi_valid(valid[1]), .axi_ready(ready[1]), .axi_data(data[1]),
    .uart_tx(tx[1]), .busy(busy[1]), .fifo_level(level[1]));

`ifdef UART_TX_PARITY_EN
  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst(rst), .axi_valid(valid[2]), .axi_ready(ready[2]), .axi_data(data[2]),
    .uart_tx(tx[2]), .busy(busy[2]), .fifo_level(level[2]));

  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .axi_valid(valid[3]), .axi_ready(ready[3]), .axi_data(data[3]),
    .uart_tx(tx[3]), .busy(busy[3]), .fifo_level(level[3]));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cpb_of(input int s);
    return (s == 1) ? 1 : 4;
  endfunction

  function automatic int stops_of(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int par_of(input int s);
    return (s >= 2) ? 1 : 0;
  endfunction

  function automatic logic odd_of(input int s);
    return (s == 3);
  endfunction

  // Expected line level at bit position pos of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int pos, input int par, input logic odd);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (par != 0 && pos == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // Called on the negedge after the first push edge. Checks every cycle of
  // every queued frame, then checks the return to idle.
  task automatic expect_frames(input int s, input string tag);
    int cpb;
    int fl;
    int f;
    logic [7:0] d;
    cpb = cpb_of(s);
    fl  = (1 + 8 + par_of(s) + stops_of(s)) * cpb;
    f   = 0;
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      for (int c = 0; c < fl; c++) begin
        @(negedge clk);
        chk($sformatf("%s f%0d c%0d line", tag, f, c), 32'(tx[s]),
            32'(exp_bit(d, c / cpb, par_of(s), odd_of(s))));
        chk($sformatf("%s f%0d c%0d busy", tag, f, c), 32'(busy[s]), 32'd1);
      end
      f++;
    end
    @(negedge clk);
    chk({tag, " idle line"}, 32'(tx[s]), 32'd1);
    chk({tag, " idle busy"}, 32'(busy[s]), 32'd0);
    chk({tag, " idle level"}, 32'(level[s]), 32'd0);
  endtask

  task automatic push_one(input int s, input logic [7:0] d);
    valid[s] = 1'b1;
    data[s]  = d;
    @(negedge clk);
    valid[s] = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    w6 = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'hFF, 8'h00};
    rst = 1'b1;
    for (int s = 0; s < NDUT; s++) begin
      valid[s] = 1'b0;
      data[s]  = 8'h00;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int s = 0; s < NDUT; s++) begin
      chk($sformatf("rst%0d tx", s), 32'(tx[s]), 32'd1);
      chk($sformatf("rst%0d busy", s), 32'(busy[s]), 32'd0);
      chk($sformatf("rst%0d level", s), 32'(level[s]), 32'd0);
      chk($sformatf("rst%0d ready", s), 32'(ready[s]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < NDUT; s++) chk($sformatf("post-rst%0d ready", s), 32'(ready[s]), 32'd1);

    // Single frame 0xA5: level goes to 1 first, start bit follows one cycle later.
    push_one(0, 8'hA5);
    chk("a5 level", 32'(level[0]), 32'd1);
    chk("a5 tx before start", 32'(tx[0]), 32'd1);
    chk("a5 busy before start", 32'(busy[0]), 32'd0);
    exp_q = '{8'hA5};
    expect_frames(0, "a5");

    // Six words pushed with valid held high; frames must run back to back.
    for (int k = 0; k < 6; k++) exp_q.push_back(w6[k]);
    fork
      begin : push_thr
        int i;
        int guard;
        logic acc;
        i = 0;
        guard = 0;
        valid[0] = 1'b1;
        data[0]  = w6[0];
        while (i < 6 && guard < 400) begin
          acc = ready[0];
          @(negedge clk);
          guard++;
          if (acc) begin
            i++;
            if (i == 5) begin
              chk("b2b ready after 5th push", 32'(ready[0]), 32'd0);
              chk("b2b level full", 32'(level[0]), 32'd4);
            end
            if (i < 6) data[0] = w6[i];
          end
        end
        valid[0] = 1'b0;
        chk("b2b all pushed", 32'(i), 32'd6);
      end
      begin
        @(negedge clk);
        expect_frames(0, "b2b");
      end
    join

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0.
    push_one(2, 8'h07);
    exp_q = '{8'h07};
    expect_frames(2, "par_even");
    push_one(3, 8'h07);
    exp_q = '{8'h07};
    expect_frames(3, "par_odd");
`endif

    // Two stop bits at one clock per bit: 0x00 then 0xFF.
    valid[1] = 1'b1;
    data[1]  = 8'h00;
    @(negedge clk);
    data[1]  = 8'hFF;
    exp_q = '{8'h00, 8'hFF};
    fork
      begin
        @(negedge clk);
        valid[1] = 1'b0;
      end
      expect_frames(1, "stop2");
    join

    // Reset in the middle of a data bit with three words queued.
    for (int k = 0; k < 4; k++) begin
      valid[0] = 1'b1;
      data[0]  = w6[k];
      @(negedge clk);
    end
    valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst level before", 32'(level[0]), 32'd3);
    chk("midrst busy before", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst ready during rst", 32'(ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst tx", 32'(tx[0]), 32'd1);
    chk("midrst busy", 32'(busy[0]), 32'd0);
    chk("midrst level", 32'(level[0]), 32'd0);
    chk("midrst ready", 32'(ready[0]), 32'd1);
    push_one(0, 8'h3C);
    exp_q = '{8'h3C};
    expect_frames(0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
